// File: rtl/pc_unit.sv
// pc_unit: program counter with branch redirect, return-address stack and
// exception entry/return.
//
// Next-PC priority (highest first): exc_req, eret, redirect_valid, ret,
// stall, sequential advance.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   stall          in   hold PC; suppress sequential advance, call push and ret
//   redirect_valid in   load redirect_pc
//   redirect_pc    in   redirect target
//   call           in   with redirect_valid and no stall: push pc_plus on the RAS
//   ret            in   pop the RAS and jump to the popped address
//   exc_req        in   jump to EXC_VEC and save the current PC in epc
//   eret           in   jump back to epc
//   pc_out         out  current PC (registered)
//   pc_plus        out  pc_out + INC, modulo 2^WIDTH
//   epc            out  saved exception PC (registered)
//   ras_empty      out  RAS holds no entries
//   ras_full       out  RAS holds RAS_DEPTH entries
//   ret_err        out  one-cycle pulse: ret taken with an empty RAS
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0080),
  parameter logic [WIDTH-1:0] INC       = WIDTH'(32'd4),
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             call,
  input  logic             ret,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_err
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  // top_q is the next write slot; the newest entry sits one below it.
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ret_err_q, ret_err_d;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [PW-1:0]    top_inc_s;
  logic [PW-1:0]    top_dec_s;
  logic             push_s;
  logic [WIDTH-1:0] pc_plus_s;

  assign pc_plus_s = pc_q + INC;

  // Circular pointer neighbours, explicit wrap so non-power-of-two depths work.
  always_comb begin
    top_inc_s = (top_q == PTR_LAST) ? '0 : top_q + PW'(1);
    top_dec_s = (top_q == '0) ? PTR_LAST : top_q - PW'(1);
  end

  // Next-state selection in strict priority order.
  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ret_err_d = 1'b0;
    push_s    = 1'b0;
    if (exc_req) begin
      pc_d  = EXC_VEC;
      epc_d = pc_q;
    end else if (eret) begin
      pc_d = epc_q;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
      if (call && !stall) begin
        // When full, the write slot is the oldest entry: overwrite it and
        // keep the count saturated.
        push_s = 1'b1;
        top_d  = top_inc_s;
        cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
      end else begin
        push_s = 1'b0;
      end
    end else if (ret && !stall) begin
      if (cnt_q != '0) begin
        pc_d  = ras_mem[top_dec_s];
        top_d = top_dec_s;
        cnt_d = cnt_q - CW'(1);
      end else begin
        pc_d      = pc_plus_s;
        ret_err_d = 1'b1;
      end
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus_s;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      top_q     <= '0;
      cnt_q     <= '0;
      ret_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      top_q     <= top_d;
      cnt_q     <= cnt_d;
      ret_err_q <= ret_err_d;
    end
  end

  // RAS entry storage; slots above the count are never read, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_mem[top_q] <= pc_plus_s;
    end
  end

  assign pc_out    = pc_q;
  assign pc_plus   = pc_plus_s;
  assign epc       = epc_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);
  assign ret_err   = ret_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit (default parameters): directed vectors with literal
// expectations plus a per-cycle comparison against a queue-based model.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        call;
  logic        ret;
  logic        exc_req;
  logic        eret;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic [31:0] epc;
  logic        ras_empty;
  logic        ras_full;
  logic        ret_err;

  int total = 0;
  int bad   = 0;

  pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .call           (call),
    .ret            (ret),
    .exc_req        (exc_req),
    .eret           (eret),
    .pc_out         (pc_out),
    .pc_plus        (pc_plus),
    .epc            (epc),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ret_err        (ret_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: PC, EPC and a LIFO of return addresses capped at 4.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_err;
  logic [31:0] m_ras[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc  = 32'h0;
      m_epc = 32'h0;
      m_err = 1'b0;
      m_ras.delete();
    end else begin
      m_err = 1'b0;
      if (exc_req) begin
        m_epc = m_pc;
        m_pc  = 32'h80;
      end else if (eret) begin
        m_pc = m_epc;
      end else if (redirect_valid) begin
        if (call && !stall) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        m_pc = redirect_pc;
      end else if (ret && !stall) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin
          m_pc  = m_pc + 32'd4;
          m_err = 1'b1;
        end
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    chk("m_pc", pc_out, m_pc);
    chk("m_pc_plus", pc_plus, m_pc + 32'd4);
    chk("m_epc", epc, m_epc);
    chk("m_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    chk("m_full", {31'd0, ras_full}, {31'd0, m_ras.size() == 4});
    chk("m_err", {31'd0, ret_err}, {31'd0, m_err});
  end

  // One clock with the given inputs, applied just after a falling edge.
  task automatic cyc(input logic st, input logic rv, input logic [31:0] rp,
                     input logic cl, input logic rt, input logic ex, input logic er);
    stall = st; redirect_valid = rv; redirect_pc = rp;
    call = cl; ret = rt; exc_req = ex; eret = er;
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    call = 1'b0; ret = 1'b0; exc_req = 1'b0; eret = 1'b0;
  endtask

  task automatic idle();   cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic jmp(input logic [31:0] t); cyc(1'b0, 1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic jal(input logic [31:0] t); cyc(1'b0, 1'b1, t, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic rtn();    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    call = 1'b0; ret = 1'b0; exc_req = 1'b0; eret = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_full", {31'd0, ras_full}, 32'd0);
    chk("rst_err", {31'd0, ret_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_pc0", pc_out, 32'h0);

    // Sequential run after reset release.
    idle(); chk("seq1", pc_out, 32'h4);
    idle(); chk("seq2", pc_out, 32'h8);
    idle(); chk("seq3", pc_out, 32'hC);
    chk("seq_empty", {31'd0, ras_empty}, 32'd1);

    // Call / return.
    jmp(32'h100);  chk("to100", pc_out, 32'h100);
    jal(32'h400);  chk("call400", pc_out, 32'h400);
    chk("call_nonempty", {31'd0, ras_empty}, 32'd0);
    idle();        chk("c404", pc_out, 32'h404);
    idle();        chk("c408", pc_out, 32'h408);
    rtn();         chk("ret104", pc_out, 32'h104);
    chk("ret_empty", {31'd0, ras_empty}, 32'd1);

    // Five nested calls into a 4-deep RAS, then five returns.
    jal(32'h1000); jal(32'h2000); jal(32'h3000); jal(32'h4000); jal(32'h5000);
    chk("n_pc", pc_out, 32'h5000);
    chk("n_full", {31'd0, ras_full}, 32'd1);
    rtn(); chk("pop_a5", pc_out, 32'h4004);
    rtn(); chk("pop_a4", pc_out, 32'h3004);
    rtn(); chk("pop_a3", pc_out, 32'h2004);
    rtn(); chk("pop_a2", pc_out, 32'h1004);
    chk("pop_err0", {31'd0, ret_err}, 32'd0);
    rtn(); chk("pop_under_pc", pc_out, 32'h1008);
    chk("pop_under_err", {31'd0, ret_err}, 32'd1);
    idle(); chk("err_pulse_end", {31'd0, ret_err}, 32'd0);
    chk("after_under", pc_out, 32'h100C);

    // Exception wins over stall and redirect; eret returns.
    jmp(32'h200);
    cyc(1'b1, 1'b1, 32'h999, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("exc_pc", pc_out, 32'h80);
    chk("exc_epc", epc, 32'h200);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("eret_pc", pc_out, 32'h200);

    // Stall blocks ret; call alone ignored; stalled call redirects without push.
    jal(32'h300);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_ret_pc", pc_out, 32'h300);
    chk("stall_ret_ras", {31'd0, ras_empty}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bare_call", pc_out, 32'h304);
    rtn(); chk("ret204", pc_out, 32'h204);
    cyc(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_call_pc", pc_out, 32'h500);
    chk("stall_call_nopush", {31'd0, ras_empty}, 32'd1);

    // Wrap-around.
    jmp(32'hFFFF_FFFC);
    chk("wrap_plus", pc_plus, 32'h0);
    idle(); chk("wrap_pc", pc_out, 32'h0);

    // Reset between edges discards RAS contents.
    jal(32'h600); jal(32'h700);
    chk("pre_rst_pc", pc_out, 32'h700);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc_out, 32'h0);
    chk("mid_rst_epc", epc, 32'h0);
    chk("mid_rst_empty", {31'd0, ras_empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rtn();
    chk("post_rst_pc", pc_out, 32'h4);
    chk("post_rst_err", {31'd0, ret_err}, 32'd1);
    idle();
    chk("post_rst_err_end", {31'd0, ret_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
